// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide unit owning the HI/LO registers.
// MULT/MULTU use shift-add, DIV/DIVU use restoring subtraction, both on operand
// magnitudes; the sign of the result is applied in a final FIX cycle.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_FIX  = 2'b10
   } state_t;

   localparam logic [2:0] OP_MTHI = 3'b100;
   localparam logic [2:0] OP_MTLO = 3'b101;

   // two's complement negation helpers
   function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
      return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
      return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
   endfunction

   state_t             state_r, state_nxt_s;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   p_hi_r, p_lo_r;     // product / remainder:quotient working pair
   logic [WIDTH-1:0]   mcand_r;            // multiplicand or divisor magnitude
   logic               is_div_r, neg_q_r, neg_r_r, div_zero_r;
   logic [WIDTH-1:0]   hi_r, lo_r;
   logic               done_r;
   logic               busy_s;

   logic               accept_s, is_md_s, last_s;
   logic               a_neg_s, b_neg_s;
   logic [WIDTH-1:0]   a_mag_s, b_mag_s;
   logic [WIDTH:0]     mul_sum_s, div_shift_s;
   logic               div_ge_s;
   logic [WIDTH-1:0]   div_sub_s;
   logic [WIDTH-1:0]   step_hi_s, step_lo_s;
   logic [2*WIDTH-1:0] prod_s, prod_fix_s;
   logic [WIDTH-1:0]   res_hi_s, res_lo_s;

   // request decode and operand magnitudes (op[0]=0 selects the signed variants)
   always_comb begin
      accept_s = (state_r == S_IDLE) && start && !cancel;
      is_md_s  = (op[2] == 1'b0);
      last_s   = (cnt_r == CNT_W'(WIDTH-1));
      a_neg_s  = !op[0] && a[WIDTH-1];
      b_neg_s  = !op[0] && b[WIDTH-1];
      a_mag_s  = a_neg_s ? neg_w(a) : a;
      b_mag_s  = b_neg_s ? neg_w(b) : b;
   end

   // one radix-2 iteration: shift-add for multiply, restoring subtract for divide
   always_comb begin
      mul_sum_s   = {1'b0, p_hi_r} + (p_lo_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
      div_shift_s = {p_hi_r, p_lo_r[WIDTH-1]};
      div_ge_s    = (div_shift_s >= {1'b0, mcand_r});
      div_sub_s   = div_shift_s[WIDTH-1:0] - mcand_r;
      if (is_div_r) begin
         if (div_ge_s) begin
            step_hi_s = div_sub_s;
            step_lo_s = {p_lo_r[WIDTH-2:0], 1'b1};
         end else begin
            step_hi_s = div_shift_s[WIDTH-1:0];
            step_lo_s = {p_lo_r[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_hi_s = mul_sum_s[WIDTH:1];
         step_lo_s = {mul_sum_s[0], p_lo_r[WIDTH-1:1]};
      end
   end

   // sign correction and divide-by-zero override applied in FIX
   always_comb begin
      prod_s     = {p_hi_r, p_lo_r};
      prod_fix_s = neg_q_r ? neg_2w(prod_s) : prod_s;
      if (is_div_r) begin
         if (div_zero_r) begin
            res_lo_s = {WIDTH{1'b1}};
         end else begin
            res_lo_s = neg_q_r ? neg_w(p_lo_r) : p_lo_r;
         end
         res_hi_s = neg_r_r ? neg_w(p_hi_r) : p_hi_r;
      end else begin
         res_hi_s = prod_fix_s[2*WIDTH-1:WIDTH];
         res_lo_s = prod_fix_s[WIDTH-1:0];
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // next-state logic; cancel aborts RUN/FIX immediately
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s && is_md_s) begin
               state_nxt_s = S_RUN;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (cancel) begin
               state_nxt_s = S_IDLE;
            end else if (last_s) begin
               state_nxt_s = S_FIX;
            end else begin
               state_nxt_s = S_RUN;
            end
         end
         S_FIX:   state_nxt_s = S_IDLE;
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // output decode from state
   always_comb begin
      case (state_r)
         S_RUN:   busy_s = 1'b1;
         S_FIX:   busy_s = 1'b1;
         default: busy_s = 1'b0;
      endcase
   end

   // datapath, HI/LO and done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r      <= {CNT_W{1'b0}};
         p_hi_r     <= {WIDTH{1'b0}};
         p_lo_r     <= {WIDTH{1'b0}};
         mcand_r    <= {WIDTH{1'b0}};
         is_div_r   <= 1'b0;
         neg_q_r    <= 1'b0;
         neg_r_r    <= 1'b0;
         div_zero_r <= 1'b0;
         hi_r       <= {WIDTH{1'b0}};
         lo_r       <= {WIDTH{1'b0}};
         done_r     <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (accept_s && is_md_s) begin
                  cnt_r      <= {CNT_W{1'b0}};
                  p_hi_r     <= {WIDTH{1'b0}};
                  p_lo_r     <= op[1] ? a_mag_s : b_mag_s;
                  mcand_r    <= op[1] ? b_mag_s : a_mag_s;
                  is_div_r   <= op[1];
                  neg_q_r    <= a_neg_s ^ b_neg_s;
                  neg_r_r    <= op[1] && a_neg_s;
                  div_zero_r <= op[1] && (b == {WIDTH{1'b0}});
               end else if (accept_s && (op == OP_MTHI)) begin
                  hi_r   <= a;
                  done_r <= 1'b1;
               end else if (accept_s && (op == OP_MTLO)) begin
                  lo_r   <= a;
                  done_r <= 1'b1;
               end
            end
            S_RUN: begin
               if (!cancel) begin
                  p_hi_r <= step_hi_s;
                  p_lo_r <= step_lo_s;
                  cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            S_FIX: begin
               if (!cancel) begin
                  hi_r   <= res_hi_s;
                  lo_r   <= res_lo_s;
                  done_r <= 1'b1;
               end
            end
            default: begin
               done_r <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_s;
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit. It is the sequential companion to the combinational ALU in the MIPS150 datapath. It executes MULT, MULTU, DIV and DIVU over WIDTH cycles using a radix-2 shift-add / restoring-subtract algorithm, and it owns the architectural HI/LO registers. The block sits beside the ALU in EX. The pipeline stalls on `busy` when MFHI/MFLO or a new mul/div arrives while an operation is in flight.

Parameters:
WIDTH, 32, operand width and width of each of HI and LO (must be >= 4, even)
CNT_W, 6, iteration counter width (must satisfy 2^CNT_W > WIDTH)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
start  in  1  request; sampled only when busy=0
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
a  in  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source)
b  in  WIDTH  rt operand (multiplier / divisor)
cancel  in  1  abort the in-flight operation (exception flush)
busy  out  1  operation in flight; new start ignored
done  out  1  one-cycle pulse: HI/LO were updated at the preceding edge
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset overrides start and cancel, and aborts any in-flight operation.
- FSM states: IDLE, RUN, FIX.
- IDLE, start=1, op in {MULT, MULTU, DIV, DIVU}:
  - Latch the magnitudes of a and b. For signed ops, also latch the result signs.
  - Go to RUN, counter=0, busy=1.
- IDLE, start=1, op=MTHI or MTLO: hi<=a (or lo<=a) at that edge. done=1 next cycle. busy stays 0.
- IDLE, start=1, op reserved: no state change and no done pulse.
- RUN: one radix-2 step per edge. After WIDTH steps go to FIX.
- FIX:
  - Apply the sign correction.
  - Write hi/lo, go to IDLE, busy=0, done=1 for one cycle.
- Latency: busy high for exactly WIDTH+1 cycles after the start edge. hi/lo and done update at edge WIDTH+1 after the start edge (33 for WIDTH=32).
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned. No overflow.
- DIV/DIVU:
  - lo=quotient, hi=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (b=0):
  - lo = all ones, hi = a.
  - Same latency as a normal divide; done pulses normally.
- Signed overflow (a = most-negative, b = -1): lo = a, hi = 0.
- start while busy=1: ignored. Operands are not re-latched and the result is not affected.
- cancel=1 in RUN or FIX: go to IDLE at that edge, busy=0, no done, hi/lo unchanged.
- cancel=1 in IDLE: no effect. If start is also 1 in the same cycle, cancel wins and the start is dropped.
- hi/lo change only at FIX completion, at MTHI/MTLO, or at reset. They hold the old values throughout RUN.
- done is never asserted in two consecutive cycles unless a new MTHI/MTLO is accepted in the cycle where done is high. Such back-to-back MTHI/MTLO is permitted.

Test Plan:
- Reset: rst_n=0 for 2 cycles with start=1, op=MULT -> hi=0, lo=0, busy=0, done=0 throughout; no operation starts.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy 33 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done pulse of exactly 1 cycle at edge 33.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIV corners:
  - DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
  - DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Flow control:
  - start DIVU 100/7, then start MULTU 3/3 during RUN -> ignored; result lo=14, hi=2.
  - Assert cancel at cycle 10 -> busy drops at that edge, no done, hi/lo keep their prior values.
  - MTHI a=0x1234 then MTLO a=0x5678 on consecutive cycles -> hi=0x1234, lo=0x5678, two done pulses, busy stays 0.
